// File: rtl/tmr_triplet_arb_pkg.sv
// Shared types for the time-TMR triplet arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: arbiter state enum, triplet beat counter type, triplet length.
package tmr_triplet_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  typedef logic [1:0] cnt_t;

  // Number of redundant copies that make up one triplet.
  localparam cnt_t TripletLen = 2'd3;

endpackage

// File: rtl/tmr_arb_rr_pick.sv
// Round-robin pick: first asserted request at or after rr_ptr_i, wrapping.
// Latency: combinational.
// Backpressure: none; pure selection logic.
// Ports: req_i (request vector), rr_ptr_i (search start),
//        idx_o (chosen index, 0 when nothing found), found_o (any request).
module tmr_arb_rr_pick #(
  parameter int unsigned NumIn = 3
) (
  input  logic [NumIn-1:0]         req_i,
  input  logic [$clog2(NumIn)-1:0] rr_ptr_i,
  output logic [$clog2(NumIn)-1:0] idx_o,
  output logic                     found_o
);

  localparam int unsigned IdxW = $clog2(NumIn);

  always_comb begin
    int unsigned j;
    j       = 0;
    idx_o   = '0;
    found_o = 1'b0;
    for (int unsigned i = 0; i < NumIn; i++) begin
      j = (32'(rr_ptr_i) + i) % NumIn;
      if (!found_o && req_i[IdxW'(j)]) begin
        found_o = 1'b1;
        idx_o   = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/tmr_triplet_arbiter.sv
// Arbitrates NumIn opgroup result streams onto the time-TMR end stage, one whole triplet per grant.
// Latency: combinational forward path (req/data/id/idx); arbitration state updates on clk_i.
// Backpressure: gnt_o[sel] mirrors gnt_i; non-selected requesters stall; held while lock_i asks for it.
// Optional feature macro: TMR_ARB_TIMEOUT_EN (forced release after LockTimeout idle LOCKED cycles).
// Ports: clk_i/rst_i (sync, active-high), flush_i, lock_i; upstream req_i/gnt_o/data_i/id_i;
//        downstream req_o/gnt_i/data_o/id_o/idx_o; timeout_o pulses on forced release.
module tmr_triplet_arbiter
  import tmr_triplet_arb_pkg::*;
#(
  parameter int unsigned NumIn       = 3,
  parameter type         DataType    = logic [7:0],
  parameter int unsigned IDSize      = 5,
  parameter int unsigned LockTimeout = 5
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              flush_i,
  input  logic                              lock_i,
  input  logic [NumIn-1:0]                  req_i,
  output logic [NumIn-1:0]                  gnt_o,
  input  DataType [NumIn-1:0]               data_i,
  input  logic [NumIn-1:0][IDSize-1:0]      id_i,
  output logic                              req_o,
  input  logic                              gnt_i,
  output DataType                           data_o,
  output logic [IDSize-1:0]                 id_o,
  output logic [$clog2(NumIn)-1:0]          idx_o,
  output logic                              timeout_o
);

  localparam int unsigned IdxW = $clog2(NumIn);

  state_e            state_q;
  logic [IdxW-1:0]   rr_ptr_q;
  logic [IdxW-1:0]   lock_idx_q;
  logic [IDSize-1:0] lock_id_q;
  cnt_t              cnt_q;
  cnt_t              cnt_nxt;

  logic [IdxW-1:0]   pick_idx;
  logic              pick_found;
  logic [IdxW-1:0]   sel;
  logic              hs;
  logic              timeout_fire;

  tmr_arb_rr_pick #(
    .NumIn (NumIn)
  ) u_pick (
    .req_i    (req_i),
    .rr_ptr_i (rr_ptr_q),
    .idx_o    (pick_idx),
    .found_o  (pick_found)
  );

  // While locked only the latched requester is visible; in reset everything
  // collapses to index 0 with no valid.
  always_comb begin
    sel   = '0;
    req_o = 1'b0;
    if (!rst_i) begin
      if (state_q == LOCKED) begin
        sel   = lock_idx_q;
        req_o = req_i[lock_idx_q];
      end else begin
        sel   = pick_idx;
        req_o = pick_found;
      end
    end
  end

  assign data_o = data_i[sel];
  assign id_o   = id_i[sel];
  assign idx_o  = sel;
  assign hs     = req_o & gnt_i;

  always_comb begin
    gnt_o = '0;
    if (!flush_i) gnt_o[sel] = hs;
  end

  // A handshake either starts a new triplet (from IDLE or on an ID change)
  // or extends the current one, saturating at the triplet length.
  always_comb begin
    cnt_nxt = cnt_q;
    if (hs) begin
      if (state_q == IDLE || id_i[sel] != lock_id_q) cnt_nxt = 2'd1;
      else if (cnt_q != TripletLen)                  cnt_nxt = cnt_q + 2'd1;
    end
  end

`ifdef TMR_ARB_TIMEOUT_EN
  localparam int unsigned TcntW = $clog2(LockTimeout + 1);

  logic [TcntW-1:0] tcnt_q;
  logic             timeout_q;

  // Fire on the idle cycle that would bring tcnt up to LockTimeout.
  assign timeout_fire = (state_q == LOCKED) && !hs && (tcnt_q == TcntW'(LockTimeout - 1));
  assign timeout_o    = timeout_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_fire;
      if (state_q == LOCKED && !hs && !timeout_fire) begin
        if (tcnt_q != TcntW'(LockTimeout)) tcnt_q <= tcnt_q + 1'b1;
      end else begin
        tcnt_q <= '0;
      end
    end
  end
`else
  assign timeout_fire = 1'b0;
  assign timeout_o    = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      lock_id_q  <= '0;
      cnt_q      <= '0;
    end else if (flush_i) begin
      // rr_ptr is kept so fairness survives a pipeline flush.
      state_q    <= IDLE;
      lock_idx_q <= '0;
      lock_id_q  <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs) begin
            state_q    <= LOCKED;
            lock_idx_q <= sel;
            lock_id_q  <= id_i[sel];
            cnt_q      <= 2'd1;
          end
        end
        LOCKED: begin
          if (timeout_fire || (cnt_nxt == TripletLen && !lock_i)) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rr_ptr_q <= (lock_idx_q == IdxW'(NumIn - 1)) ? '0 : lock_idx_q + 1'b1;
          end else begin
            cnt_q <= cnt_nxt;
            if (hs) lock_id_q <= id_i[sel];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
